// File: rtl/freq_meter_probe.sv
`default_nettype none
// ============================================================================
//  Module   : freq_meter_probe
//  Purpose  : Gated edge-counting frequency meter. Synchronises an async
//             signal under test, counts its rising edges over a programmable
//             number of clk cycles and presents the latched, saturating count
//             as a byte-selectable word for the pad wrapper.
//  Ports    : clk, rst        - clock, async active-high reset
//             start           - measurement request (honoured only in IDLE)
//             gate_len        - window length in clk cycles (captured on start)
//             sig_in          - asynchronous signal under test
//             byte_sel        - 0: result[7:0], 1: result[CNT_W-1:8] zero-ext
//             busy            - high in ARM and COUNT
//             done            - one-cycle pulse when result is updated
//             overflow        - last completed measurement saturated
//             result          - last completed count
//             dout            - byte view of result (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module freq_meter_probe #(
    parameter int CNT_W       = 12,
    parameter int GATE_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              sig_in,
    input  logic              byte_sel,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  result,
    output logic [7:0]        dout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_COUNT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]  C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
    localparam logic [GATE_W-1:0] C_GATE_ONE = GATE_W'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [GATE_W-1:0]      glen_q, glen_d;
    logic [GATE_W-1:0]      gcnt_q, gcnt_d;
    logic [CNT_W-1:0]       ecnt_q, ecnt_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       result_q, result_d;
    logic                   overflow_q, overflow_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   w_s;
    logic                   w_rise;
    logic [15:0]            w_res_ext;

    // Synchronised sample is the last stage of the shift chain.
    assign w_s    = sync_q[SYNC_STAGES-1];
    assign w_rise = w_s & ~prev_q;

    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[SYNC_STAGES-2:0], sig_in};
        prev_d     = w_s;
        glen_d     = glen_q;
        gcnt_d     = gcnt_q;
        ecnt_d     = ecnt_q;
        sat_d      = sat_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    glen_d  = gate_len;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // Edges seen in this cycle are deliberately discarded.
                gcnt_d  = '0;
                ecnt_d  = '0;
                sat_d   = 1'b0;
                state_d = (glen_q != '0) ? ST_COUNT : ST_DONE;
            end
            ST_COUNT: begin
                if (w_rise) begin
                    if (ecnt_q == C_CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        ecnt_d = ecnt_q + C_CNT_ONE;
                    end
                end
                gcnt_d = gcnt_q + C_GATE_ONE;
                if (gcnt_q == glen_q - C_GATE_ONE) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Latch on the edge entering DONE so the final COUNT cycle's edge
        // is included in the published value.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            result_d   = ecnt_d;
            overflow_d = sat_d;
        end

        busy_d = (state_d == ST_ARM) || (state_d == ST_COUNT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            glen_q     <= '0;
            gcnt_q     <= '0;
            ecnt_q     <= '0;
            sat_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            glen_q     <= glen_d;
            gcnt_q     <= gcnt_d;
            ecnt_q     <= ecnt_d;
            sat_q      <= sat_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Zero-extend to 16 bits so the upper byte view is valid for any CNT_W.
    assign w_res_ext = 16'(result_q);
    assign dout      = byte_sel ? w_res_ext[15:8] : w_res_ext[7:0];

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign result   = result_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_meter_probe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_meter_probe
//  Purpose  : Self-checking bench for freq_meter_probe using an expected-
//             result queue filled at start and drained on done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_meter_probe;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] gate_len;
    logic        sig_in;
    logic        byte_sel;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [11:0] result;
    logic [7:0]  dout;

    freq_meter_probe #(
        .CNT_W       (12),
        .GATE_W      (16),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .gate_len (gate_len),
        .sig_in   (sig_in),
        .byte_sel (byte_sel),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .result   (result),
        .dout     (dout)
    );

    typedef struct {
        int res;
        int ovf;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   sig_mode = 0;   // 0: constant level, 1: period-10 square, 2: toggle every clk
    logic sig_lvl  = 1'b0;
    int   cyc      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Signal-under-test generator, updated just after each rising edge.
    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (sig_mode)
                1:       sig_in = ((cyc % 10) < 5);
                2:       sig_in = cyc[0];
                default: sig_in = sig_lvl;
            endcase
        end
    end

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One full measurement: expectation queued at start, checked on done.
    task automatic run_meas(input int glen, input int er, input int eo, input bit disturb);
        exp_t e;
        exp_t g;
        int   busy_n;
        bit   seen;
        e.res = er;
        e.ovf = eo;
        e.lat = glen + 2;
        sb.push_back(e);
        busy_n = 0;
        seen   = 1'b0;

        @(negedge clk);
        start    = 1'b1;
        gate_len = 16'(glen);
        @(posedge clk);              // edge 0: start sampled
        for (int k = 1; k <= glen + 50; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                gate_len = 16'($urandom_range(1, 9));   // must not affect window
            end
            if (busy) busy_n++;
            if (disturb && k == 20) start = 1'b1;
            if (disturb && k == 21) start = 1'b0;
            if (done) begin
                g = sb.pop_front();
                check_val("done_cycle", k, g.lat);
                check_val("busy_cycles", busy_n, g.lat - 1);
                check_val("result", int'(result), g.res);
                check_val("overflow", int'(overflow), g.ovf);
                byte_sel = 1'b0;
                #1;
                check_val("dout_lo", int'(dout), g.res & 8'hFF);
                byte_sel = 1'b1;
                #1;
                check_val("dout_hi", int'(dout), (g.res >> 8) & 8'hFF);
                byte_sel = 1'b0;
                if (disturb) start = 1'b1;   // sampled while in DONE
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check_val("done_timeout", 0, 1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        @(negedge clk);
        start = 1'b0;
        check_val("done_pulse_width", int'(done), 0);
        check_val("idle_busy", int'(busy), 0);
        if (disturb) begin
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check_val("no_queued_start", int'(busy | done), 0);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        gate_len = '0;
        byte_sel = 1'b0;

        // 1: reset with the input toggling
        sig_mode = 2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("rst_outputs", int'({busy, done, overflow}), 0);
            check_val("rst_result", int'(result), 0);
            check_val("rst_dout", int'(dout), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check_val("post_rst_outputs", int'({busy, done, overflow}), 0);
        check_val("post_rst_result", int'(result), 0);
        check_val("post_rst_dout", int'(dout), 0);

        // 2: 100-cycle window on a period-10 square wave
        sig_mode = 1;
        repeat (30) @(negedge clk);
        run_meas(100, 10, 0, 1'b0);

        // 3: zero-length window
        run_meas(0, 0, 0, 1'b0);

        // 4: saturation with an edge every 2 cycles
        sig_mode = 2;
        repeat (5) @(negedge clk);
        run_meas(10000, 12'hFFF, 1, 1'b0);

        // 5: stray starts during COUNT/DONE and gate_len changes mid-window
        sig_mode = 1;
        repeat (5) @(negedge clk);
        run_meas(50, 5, 0, 1'b1);

        // 6: reset halfway through a 100-cycle window
        @(negedge clk);
        start    = 1'b1;
        gate_len = 16'd100;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        check_val("mid_window_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_result", int'(result), 0);
        check_val("abort_done_ovf", int'({done, overflow}), 0);
        sig_mode = 0;
        sig_lvl  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_val("abort_result_held", int'(result), 0);
        run_meas(100, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/freq_meter_probe.md
Name: freq_meter_probe

Overview:
- Gated edge-counting frequency meter that sits directly upstream of the chip-level pad wrapper.
- Consumes the digitised output of an analog test cell, such as a comparator or ring-oscillator divider brought in on a dedicated input.
- Counts rising edges over a programmable number of clk cycles and presents the latched count as a byte-selectable word that the wrapper drives onto its output pins.

Parameters:
- CNT_W, 12, width of the edge counter and result; legal range 9..16.
- GATE_W, 16, width of the gate-length operand.
- SYNC_STAGES, 2, flops in the sig_in synchroniser; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a measurement; sampled only in IDLE.
- gate_len  input  GATE_W  window length in clk cycles; captured when start is accepted.
- sig_in  input  1  asynchronous signal under test.
- byte_sel  input  1  0 selects result[7:0]; 1 selects result[CNT_W-1:8] zero-extended to 8 bits.
- busy  output  1  high in ARM and COUNT.
- done  output  1  single-cycle pulse when result is updated.
- overflow  output  1  the last completed measurement saturated.
- result  output  CNT_W  last completed count.
- dout  output  8  byte view of result, combinational from result and byte_sel.

Behaviour:
- Reset (asynchronous assert, synchronous use after release):
  - FSM goes to IDLE.
  - busy=0, done=0, overflow=0, result=0.
  - Synchroniser, edge-detect history, gate counter and edge counter all go to 0.
- sig_in passes through SYNC_STAGES flops. The synchronised bit is s.
  - A rising edge is s=1 while prev=0.
  - prev is a register that tracks s every cycle.
- FSM states and transitions:
  - IDLE: if start=1, capture gate_len into glen and go to ARM. Otherwise stay.
  - ARM (1 cycle):
    - Clear the edge counter and the gate counter. Edges seen in this cycle are not counted.
    - Go to COUNT if glen != 0, else go to DONE.
  - COUNT:
    - Each cycle, increment the edge counter on a rising edge.
    - Increment the gate counter every cycle.
    - Leave for DONE after exactly glen COUNT cycles, i.e. when the gate counter equals glen-1.
  - DONE (1 cycle): done=1, then go to IDLE.
- Latency:
  - start is sampled at edge 0, so ARM occupies cycle 1 and COUNT occupies cycles 2..glen+1.
  - DONE is cycle glen+2, with result and overflow registered on the edge that enters DONE.
  - For glen=0, DONE is cycle 2.
- Saturation:
  - The edge counter stops at 2^CNT_W-1 and never wraps.
  - A further edge at the maximum sets an internal sat flag.
  - overflow is loaded from sat together with result.
- result and overflow hold their values until the next DONE. They are not cleared by start.
- start outside IDLE (ARM, COUNT or DONE) is ignored and not queued.
- gate_len changes after capture have no effect on the running measurement.
- rst mid-measurement aborts it. All outputs return to their reset values and the previous result is lost.
- Edges arriving within SYNC_STAGES cycles before the window closes are counted in the next measurement only if they are still pending at its ARM, which they will not be. They are therefore dropped; this is acceptable.
- Maximum countable rate is one edge per 2 clk cycles.

Test Plan:
1. Assert rst with sig_in toggling -> busy=0, done=0, overflow=0, result=0, dout=0x00 throughout reset and on the first cycle after release.
2. gate_len=100, sig_in a 10-cycle-period square wave started well before start -> busy high for 101 cycles, done pulses exactly at cycle 102 after start, result=10, overflow=0, dout=0x0A with byte_sel=0 and 0x00 with byte_sel=1.
3. gate_len=0 -> done at cycle 2 after start, result=0, COUNT never entered.
4. gate_len=10000, sig_in toggling every clk (period 2) -> 5000 edges saturate. Required: result=0xFFF, overflow=1, dout=0xFF with byte_sel=0 and 0x0F with byte_sel=1.
5. Pulse start repeatedly during COUNT and DONE -> ignored, exactly one done per accepted start. Change gate_len mid-window -> window length is unchanged.
6. Assert rst at cycle 50 of a 100-cycle window -> immediate busy=0 and result=0. A new start after release with sig_in held constant high -> result=0, done at cycle glen+2.
